// File: rtl/regbank_pkg.sv
// Shared defaults and clear-sequencer state type for the regbank_param register file.
package regbank_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NREGS   = 18;
  localparam int DEF_AW      = 5;
  localparam int DEF_SP_IDX  = 16;
  localparam int DEF_PC_IDX  = 17;
  localparam int DEF_PC_STEP = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regbank_bypass.sv
// One read port: range check plus write-first bypass (port 1 over port 0), zero latency.
// REGBANK_R0_ZERO_EN makes index 0 read as zero and never bypass.
module regbank_bypass
  import regbank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int NREGS = DEF_NREGS
) (
  input  logic [AW-1:0]    sr,
  input  logic             byp_en,
  input  logic             wr0_en,
  input  logic [AW-1:0]    dr0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             wr1_en,
  input  logic [AW-1:0]    dr1,
  input  logic [WIDTH-1:0] wd1,
  input  logic [WIDTH-1:0] stored,
  output logic [WIDTH-1:0] rdata
);

  logic readable;

`ifdef REGBANK_R0_ZERO_EN
  assign readable = (int'(sr) < NREGS) && (sr != '0);
`else
  assign readable = (int'(sr) < NREGS);
`endif

  always_comb begin
    rdata = '0;
    if (readable) begin
      if (byp_en && wr1_en && (dr1 == sr))
        rdata = wd1;
      else if (byp_en && wr0_en && (dr0 == sr))
        rdata = wd0;
      else
        rdata = stored;
    end
  end

endmodule

// File: rtl/regbank_param.sv
// NREGS x WIDTH register bank: 2 comb read ports with bypass, 2 write ports, PC increment, multi-cycle clear.
// REGBANK_R0_ZERO_EN hardwires R0 to zero; writes/pc_inc/clr_req are ignored while clr_busy.
module regbank_param
  import regbank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int AW      = DEF_AW,
  parameter int SP_IDX  = DEF_SP_IDX,
  parameter int PC_IDX  = DEF_PC_IDX,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] rData1,
  output logic [WIDTH-1:0] rData2,
  input  logic             write0,
  input  logic [AW-1:0]    dr0,
  input  logic [WIDTH-1:0] wrData0,
  input  logic             write1,
  input  logic [AW-1:0]    dr1,
  input  logic [WIDTH-1:0] wrData1,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] sp_out,
  output logic [WIDTH-1:0] pc_out,
  input  logic             clr_req,
  output logic             clr_busy
);

  clr_state_e       state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] stored1, stored2;
  logic             wr0_ok, wr1_ok, idle;

  assign idle = (state_q == ST_IDLE);

`ifdef REGBANK_R0_ZERO_EN
  assign wr0_ok = write0 && (int'(dr0) < NREGS) && (dr0 != '0);
  assign wr1_ok = write1 && (int'(dr1) < NREGS) && (dr1 != '0);
`else
  assign wr0_ok = write0 && (int'(dr0) < NREGS);
  assign wr1_ok = write1 && (int'(dr1) < NREGS);
`endif

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (int'(sr1) < NREGS) stored1 = regs_q[sr1];
    if (int'(sr2) < NREGS) stored2 = regs_q[sr2];
  end

  regbank_bypass #(.WIDTH(WIDTH), .AW(AW), .NREGS(NREGS)) u_byp1 (
    .sr(sr1), .byp_en(idle),
    .wr0_en(write0), .dr0(dr0), .wd0(wrData0),
    .wr1_en(write1), .dr1(dr1), .wd1(wrData1),
    .stored(stored1), .rdata(rData1)
  );

  regbank_bypass #(.WIDTH(WIDTH), .AW(AW), .NREGS(NREGS)) u_byp2 (
    .sr(sr2), .byp_en(idle),
    .wr0_en(write0), .dr0(dr0), .wd0(wrData0),
    .wr1_en(write1), .dr1(dr1), .wd1(wrData1),
    .stored(stored2), .rdata(rData2)
  );

  // Later assignments win: explicit writes override the PC increment, port 1 overrides port 0.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    regs_d    = regs_q;
    case (state_q)
      ST_IDLE: begin
        if (pc_inc) regs_d[PC_IDX] = regs_q[PC_IDX] + WIDTH'(PC_STEP);
        if (wr0_ok) regs_d[dr0] = wrData0;
        if (wr1_ok) regs_d[dr1] = wrData1;
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        regs_d[clr_ptr_q] = '0;
        if (clr_ptr_q == AW'(NREGS - 1)) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      regs_q    <= regs_d;
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign sp_out   = regs_q[SP_IDX];
  assign pc_out   = regs_q[PC_IDX];

endmodule

// File: tb/tb_regbank_param.sv
// Directed self-checking bench for regbank_param (default parameters).
module tb_regbank_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sr1, sr2, dr0, dr1;
  logic [31:0] rData1, rData2, wrData0, wrData1, sp_out, pc_out;
  logic        write0, write1, pc_inc, clr_req, clr_busy;

  int n_checks = 0;
  int n_fails  = 0;
  int busy_cnt;
  logic [31:0] r0_exp;

  regbank_param dut (
    .clk(clk), .reset(reset),
    .sr1(sr1), .sr2(sr2), .rData1(rData1), .rData2(rData2),
    .write0(write0), .dr0(dr0), .wrData0(wrData0),
    .write1(write1), .dr1(dr1), .wrData1(wrData1),
    .pc_inc(pc_inc), .sp_out(sp_out), .pc_out(pc_out),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write0 = 1'b0; write1 = 1'b0; pc_inc = 1'b0; clr_req = 1'b0;
    dr0 = '0; dr1 = '0; wrData0 = '0; wrData1 = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
`ifdef REGBANK_R0_ZERO_EN
    r0_exp = 32'h0;
`else
    r0_exp = 32'hFF;
`endif
    reset = 1'b1; sr1 = '0; sr2 = '0;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    sr1 = 5'd3; sr2 = 5'd17;
    settle();
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_sp", sp_out, 32'h0);
    chk("rst_r3", rData1, 32'h0);

    // Write, same-cycle bypass, then stored value; out-of-range read
    write0 = 1'b1; dr0 = 5'd3; wrData0 = 32'hDEADBEEF;
    settle();
    chk("byp_w0", rData1, 32'hDEADBEEF);
    tick();
    idle_inputs();
    sr2 = 5'd20;
    settle();
    chk("stored_r3", rData1, 32'hDEADBEEF);
    chk("oor_read", rData2, 32'h0);

    // Dual write to same index: port 1 wins
    write0 = 1'b1; dr0 = 5'd5; wrData0 = 32'h11;
    write1 = 1'b1; dr1 = 5'd5; wrData1 = 32'h22;
    sr1 = 5'd5; sr2 = 5'd5;
    settle();
    chk("byp_p1_wins", rData1, 32'h22);
    chk("byp_p1_wins2", rData2, 32'h22);
    tick();
    idle_inputs();
    settle();
    chk("stored_r5", rData1, 32'h22);

    // PC wrap and explicit-write override of increment
    write0 = 1'b1; dr0 = 5'd17; wrData0 = 32'hFFFFFFFC;
    tick();
    idle_inputs();
    settle();
    chk("pc_load", pc_out, 32'hFFFFFFFC);
    pc_inc = 1'b1;
    tick();
    chk("pc_wrap", pc_out, 32'h0);
    write0 = 1'b1; dr0 = 5'd17; wrData0 = 32'h100;
    tick();
    chk("pc_override", pc_out, 32'h100);
    write0 = 1'b0;
    tick();
    idle_inputs();
    settle();
    chk("pc_inc", pc_out, 32'h104);
    write1 = 1'b1; dr1 = 5'd16; wrData1 = 32'hABC;
    settle();
    chk("sp_no_bypass", sp_out, 32'h0);
    tick();
    idle_inputs();
    chk("sp_write", sp_out, 32'hABC);

    // R0 behaviour
    write0 = 1'b1; dr0 = 5'd0; wrData0 = 32'hFF; sr1 = 5'd0;
    settle();
    chk("r0_same_cycle", rData1, r0_exp);
    tick();
    idle_inputs();
    settle();
    chk("r0_next_cycle", rData1, r0_exp);

    // Fill all registers, then run a full clear
    for (int i = 0; i < 18; i++) begin
      write0 = 1'b1; dr0 = 5'(i); wrData0 = 32'h1000 + 32'(i);
      tick();
    end
    idle_inputs();
    sr1 = 5'd17; sr2 = 5'd2;
    settle();
    chk("fill_r17", rData1, 32'h1011);
    chk("fill_r2", rData2, 32'h1002);
    chk("pre_clr_busy", 32'(clr_busy), 32'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    while (clr_busy && busy_cnt < 40) begin
      if (busy_cnt == 0) begin
        write1 = 1'b1; dr1 = 5'd2; wrData1 = 32'h55; sr1 = 5'd2;
        pc_inc = 1'b1;
        settle();
        chk("clr_no_bypass", rData1, 32'h1002);
      end
      busy_cnt++;
      tick();
      idle_inputs();
    end
    chk("clr_busy_len", 32'(busy_cnt), 32'd18);
    for (int i = 0; i < 18; i++) begin
      sr1 = 5'(i);
      settle();
      chk($sformatf("clr_r%0d", i), rData1, 32'h0);
    end
    chk("clr_pc", pc_out, 32'h0);

    // Reset in the middle of a clear
    write0 = 1'b1; dr0 = 5'd9; wrData0 = 32'h99;
    write1 = 1'b1; dr1 = 5'd17; wrData1 = 32'h4444;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_clr_busy", 32'(clr_busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("abort_busy", 32'(clr_busy), 32'h0);
    sr1 = 5'd9; sr2 = 5'd17;
    settle();
    chk("abort_r9", rData1, 32'h0);
    chk("abort_r17", rData2, 32'h0);
    write0 = 1'b1; dr0 = 5'd4; wrData0 = 32'h7; sr1 = 5'd4;
    tick();
    idle_inputs();
    tick(); tick();
    chk("post_abort_w", rData1, 32'h7);

    // Write to out-of-range index leaves bank intact
    write0 = 1'b1; dr0 = 5'd18; wrData0 = 32'hBAD;
    tick();
    idle_inputs();
    sr2 = 5'd18;
    settle();
    chk("oor_write_r18", rData2, 32'h0);
    chk("oor_write_r4", rData1, 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regbank_param.md
Name: regbank_param

Overview:
Parametrised next-generation register bank: NREGS x WIDTH storage, two combinational read ports and two write ports (ALU and load).
- Write-first bypass on reads.
- Dedicated SP/PC outputs with hardware PC increment.
- Multi-cycle software-requested clear sequencer.
Sits between decode (sr1/sr2) and writeback (dr0/dr1) in the processor datapath.

Parameters:
WIDTH, 32, data width in bits
NREGS, 18, number of registers (R0-R15, SP, PC); must satisfy NREGS <= 2**AW
AW, 5, register index width
SP_IDX, 16, index of stack pointer
PC_IDX, 17, index of program counter
PC_STEP, 4, PC increment amount

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
sr1  in  AW  read index, port 1
sr2  in  AW  read index, port 2
rData1  out  WIDTH  read data, port 1
rData2  out  WIDTH  read data, port 2
write0  in  1  write enable, port 0 (ALU)
dr0  in  AW  write index, port 0
wrData0  in  WIDTH  write data, port 0
write1  in  1  write enable, port 1 (load)
dr1  in  AW  write index, port 1
wrData1  in  WIDTH  write data, port 1
pc_inc  in  1  PC += PC_STEP this cycle
sp_out  out  WIDTH  current regfile[SP_IDX]
pc_out  out  WIDTH  current regfile[PC_IDX]
clr_req  in  1  pulse to start clear sequence
clr_busy  out  1  clear sequence in progress

Behaviour:
Reset:
- reset high at posedge: all NREGS registers := 0 in that single cycle; FSM := IDLE; clr_ptr := 0; clr_busy := 0.
- reset overrides every other input, including mid-clear (aborts to IDLE).

Reads (combinational, zero latency):
- Index >= NREGS reads 0.
- Bypass, IDLE only: if write1 && dr1==sr, return wrData1; else if write0 && dr0==sr, return wrData0; else regfile[sr].
- sp_out/pc_out show registered contents only (no bypass).

Writes (posedge, FSM IDLE, not reset):
- Index >= NREGS ignored.
- write0 && write1 && dr0==dr1: port 1 wins; port 0 dropped.
- pc_inc: PC := PC + PC_STEP, modulo 2**WIDTH, wraps silently. An explicit write to PC_IDX in the same cycle (either port) overrides the increment.

Clear FSM (states IDLE, CLEAR):
- IDLE: clr_req -> CLEAR, clr_ptr := 0; writes/pc_inc of that same cycle still applied.
- CLEAR: clr_busy=1; regfile[clr_ptr] := 0 per cycle; clr_ptr++. When clr_ptr==NREGS-1, that register is cleared and FSM -> IDLE next cycle. Clear takes exactly NREGS cycles.
- During CLEAR: write0/write1/pc_inc/clr_req ignored; bypass disabled; reads return current stored contents (mix of cleared/uncleared).
- clr_busy is registered: high from the cycle after clr_req through NREGS cycles.

Optional Feature:
Macro REGBANK_R0_ZERO_EN.
- Defined: R0 hardwired zero. Writes to index 0 are discarded, reads of index 0 return 0, and bypass never forwards to index 0.
- Undefined: R0 is an ordinary register.

Decomposition:
- Package regbank_pkg: default WIDTH/AW/NREGS, SP_IDX, PC_IDX, PC_STEP constants, and the clear-FSM state typedef (IDLE, CLEAR).
- One sub-module, regbank_bypass: the per-read-port range-check and priority bypass mux (inputs sr, both write ports, stored word, bypass enable), instantiated twice.

Test Plan:
- Reset, then write0 dr0=3 wrData0=32'hDEADBEEF; next cycle sr1=3 -> rData1=32'hDEADBEEF; sr2=20 -> rData2=0.
- Same cycle write0 dr0=5 wrData0=0x11, write1 dr1=5 wrData1=0x22, sr1=5 -> rData1=0x22 that cycle (bypass); stored value 0x22 afterwards.
- PC=0xFFFFFFFC, pc_inc=1 -> pc_out=0x00000000; pc_inc=1 with write0 dr0=17 wrData0=0x100 -> pc_out=0x100.
- Fill R0-R17 with nonzero values; pulse clr_req -> clr_busy high exactly 18 cycles; write1 dr1=2 during CLEAR is ignored; all registers read 0 at end.
- Assert reset at cycle 5 of CLEAR -> next cycle clr_busy=0, all registers 0; a subsequent write0 dr0=4 wrData0=0x7 is accepted.
- With REGBANK_R0_ZERO_EN: write0 dr0=0 wrData0=0xFF, sr1=0 -> rData1=0 both same-cycle and next cycle; without the macro -> 0xFF.
